// File: rtl/lifo_fifo_buffer.sv
// lifo_fifo_buffer: WIDTH x DEPTH buffer, runtime LIFO (stack) or FIFO (queue).
// Registered read data, occupancy status, sticky overflow/underflow flags.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-high reset
//   mode         requested mode (0 = LIFO, 1 = FIFO), latched only when idle+empty
//   push/pop     operation requests for this cycle
//   data_in      write data
//   clear_err    clears overflow/underflow on the next edge
//   data_out     registered read data
//   out_valid    one-cycle pulse when data_out was updated by a pop
//   count        occupancy 0..DEPTH
//   full/empty   count == DEPTH / count == 0
//   active_mode  mode currently in effect
//   overflow     sticky: push rejected while full
//   underflow    sticky: pop rejected while empty
module lifo_fifo_buffer #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mode,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] data_in,
    input  logic             clear_err,
    output logic [WIDTH-1:0] data_out,
    output logic             out_valid,
    output logic [AW:0]      count,
    output logic             full,
    output logic             empty,
    output logic             active_mode,
    output logic             overflow,
    output logic             underflow
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic [WIDTH-1:0] r_data_out;
    logic             r_out_valid;
    logic             r_mode;
    logic             r_overflow;
    logic             r_underflow;

    logic             w_empty;
    logic             w_full;
    logic             w_pop_ok;
    logic             w_push_ok;
    logic             w_push_err;
    logic             w_pop_err;
    logic             w_mode_ld;
    logic [AW-1:0]    w_top;
    logic [AW-1:0]    w_wr_addr;
    logic [AW-1:0]    w_rd_addr;
    logic [AW:0]      w_cnt_nxt;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == FULL_CNT);

    // A simultaneous successful pop frees a slot, so push is legal when full.
    assign w_pop_ok   = pop && !w_empty;
    assign w_push_ok  = push && (!w_full || w_pop_ok);
    assign w_push_err = push && !w_push_ok;
    assign w_pop_err  = pop && w_empty;
    assign w_mode_ld  = w_empty && !push && !pop;

    // Top-of-stack index; at count == DEPTH the low bits wrap to DEPTH-1.
    assign w_top = r_count[AW-1:0] - AW'(1);

    always_comb begin
        w_wr_addr = r_wr_ptr;
        w_rd_addr = r_rd_ptr;
        if (!r_mode) begin
            // Push+pop in LIFO replaces the old top in place.
            w_wr_addr = w_pop_ok ? w_top : r_count[AW-1:0];
            w_rd_addr = w_top;
        end
    end

    assign w_cnt_nxt = r_count + (AW+1)'(w_push_ok) - (AW+1)'(w_pop_ok);

    always_ff @(posedge clk) begin
        if (!reset && w_push_ok) begin
            r_mem[w_wr_addr] <= data_in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_data_out  <= '0;
            r_out_valid <= 1'b0;
            r_mode      <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_count     <= w_cnt_nxt;
            r_out_valid <= w_pop_ok;
            r_overflow  <= w_push_err || (r_overflow && !clear_err);
            r_underflow <= w_pop_err || (r_underflow && !clear_err);
            if (w_pop_ok) begin
                r_data_out <= r_mem[w_rd_addr];
            end
            if (w_mode_ld) begin
                r_mode   <= mode;
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else if (r_mode) begin
                if (w_push_ok) begin
                    r_wr_ptr <= r_wr_ptr + AW'(1);
                end
                if (w_pop_ok) begin
                    r_rd_ptr <= r_rd_ptr + AW'(1);
                end
            end
        end
    end

    assign data_out    = r_data_out;
    assign out_valid   = r_out_valid;
    assign count       = r_count;
    assign full        = w_full;
    assign empty       = w_empty;
    assign active_mode = r_mode;
    assign overflow    = r_overflow;
    assign underflow   = r_underflow;

endmodule

// File: tb/tb_lifo_fifo_buffer.sv
// tb_lifo_fifo_buffer: queue-based reference model, scoreboard for popped data,
// directed scenarios followed by randomized traffic.
module tb_lifo_fifo_buffer;

    logic       clk = 1'b0;
    logic       reset;
    logic       mode;
    logic       push;
    logic       pop;
    logic [7:0] data_in;
    logic       clear_err;
    logic [7:0] data_out;
    logic       out_valid;
    logic [4:0] count;
    logic       full;
    logic       empty;
    logic       active_mode;
    logic       overflow;
    logic       underflow;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [7:0] m_q[$];
    logic [7:0] exp_q[$];
    bit         m_mode = 0;
    bit         m_ovf  = 0;
    bit         m_udf  = 0;
    bit         m_vld  = 0;
    logic [7:0] m_dout = 8'h00;

    lifo_fifo_buffer #(.WIDTH(8), .DEPTH(16)) dut (
        .clk(clk),
        .reset(reset),
        .mode(mode),
        .push(push),
        .pop(pop),
        .data_in(data_in),
        .clear_err(clear_err),
        .data_out(data_out),
        .out_valid(out_valid),
        .count(count),
        .full(full),
        .empty(empty),
        .active_mode(active_mode),
        .overflow(overflow),
        .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: every out_valid pulse consumes one expected word.
    always @(negedge clk) begin
        if (!reset && out_valid) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb_extra: got %0h, expected no output", data_out);
            end else begin
                chk("sb_data", int'(data_out), int'(exp_q.pop_front()));
            end
        end
    end

    task automatic check_status();
        chk("count", int'(count), m_q.size());
        chk("full", int'(full), int'(m_q.size() == 16));
        chk("empty", int'(empty), int'(m_q.size() == 0));
        chk("active_mode", int'(active_mode), int'(m_mode));
        chk("overflow", int'(overflow), int'(m_ovf));
        chk("underflow", int'(underflow), int'(m_udf));
        chk("out_valid", int'(out_valid), int'(m_vld));
        chk("data_out", int'(data_out), int'(m_dout));
    endtask

    // Called at a negedge: drive, update the model, let one edge pass, check.
    task automatic step(input bit m, input bit pu, input bit po,
                        input logic [7:0] d, input bit ce);
        bit         was_empty;
        bit         was_full;
        bit         pop_ok;
        bit         push_ok;
        logic [7:0] v;
        mode      = m;
        push      = pu;
        pop       = po;
        data_in   = d;
        clear_err = ce;
        was_empty = (m_q.size() == 0);
        was_full  = (m_q.size() == 16);
        pop_ok    = po && !was_empty;
        push_ok   = pu && (!was_full || pop_ok);
        if (was_empty && !pu && !po) m_mode = m;
        if (pop_ok) begin
            // Stack pops the newest entry, queue the oldest.
            v = m_mode ? m_q.pop_front() : m_q.pop_back();
            m_dout = v;
            exp_q.push_back(v);
        end
        if (push_ok) m_q.push_back(d);
        m_vld = pop_ok;
        m_ovf = (pu && !push_ok) || (m_ovf && !ce);
        m_udf = (po && was_empty) || (m_udf && !ce);
        @(posedge clk);
        @(negedge clk);
        check_status();
    endtask

    task automatic mid_reset();
        mode      = 1'b1;
        push      = 1'b1;
        pop       = 1'b1;
        data_in   = 8'h5A;
        clear_err = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("rst_count", int'(count), 0);
        chk("rst_empty", int'(empty), 1);
        chk("rst_full", int'(full), 0);
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_dout", int'(data_out), 0);
        chk("rst_ovf", int'(overflow), 0);
        chk("rst_udf", int'(underflow), 0);
        chk("rst_mode", int'(active_mode), 0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        push  = 1'b0;
        pop   = 1'b0;
        m_q.delete();
        m_mode = 0;
        m_ovf  = 0;
        m_udf  = 0;
        m_vld  = 0;
        m_dout = 8'h00;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit         rm;
        int         pw;
        int         pp;
        reset     = 1'b1;
        mode      = 1'b0;
        push      = 1'b0;
        pop       = 1'b0;
        data_in   = 8'h00;
        clear_err = 1'b0;
        #1;
        check_status();
        @(negedge clk);
        reset = 1'b0;

        // LIFO ordering
        step(0, 1, 0, 8'h11, 0);
        step(0, 1, 0, 8'h22, 0);
        step(0, 1, 0, 8'h33, 0);
        repeat (3) step(0, 0, 1, 8'h00, 0);

        // Switch to FIFO, fill, overflow, drain in order
        step(1, 0, 0, 8'h00, 0);
        for (int i = 0; i < 16; i++) step(1, 1, 0, 8'(8'hA0 + i), 0);
        step(1, 1, 0, 8'hFF, 0);
        repeat (16) step(1, 0, 1, 8'h00, 0);
        step(1, 0, 0, 8'h00, 1);

        // FIFO pointer wrap
        for (int i = 0; i < 10; i++) step(1, 1, 0, 8'(8'h40 + i), 0);
        repeat (10) step(1, 0, 1, 8'h00, 0);
        for (int i = 0; i < 12; i++) step(1, 1, 0, 8'(8'h60 + i), 0);
        repeat (12) step(1, 0, 1, 8'h00, 0);

        // LIFO simultaneous push+pop
        step(0, 0, 0, 8'h00, 0);
        step(0, 1, 0, 8'h05, 0);
        step(0, 1, 0, 8'h06, 0);
        step(0, 1, 1, 8'h07, 0);
        step(0, 0, 1, 8'h00, 0);
        step(0, 0, 1, 8'h00, 0);

        // FIFO full push+pop, then empty push+pop
        step(1, 0, 0, 8'h00, 0);
        for (int i = 0; i < 16; i++) step(1, 1, 0, 8'(8'hC0 + i), 0);
        step(1, 1, 1, 8'hD0, 0);
        repeat (16) step(1, 0, 1, 8'h00, 0);
        step(1, 1, 1, 8'h3C, 0);
        step(1, 0, 1, 8'h00, 0);
        step(1, 0, 0, 8'h00, 1);

        // Mode-change guard while non-empty
        step(0, 0, 0, 8'h00, 0);
        step(0, 1, 0, 8'h77, 0);
        step(1, 0, 0, 8'h00, 0);
        step(1, 0, 1, 8'h00, 0);

        // Reset in the middle of a FIFO burst with overflow pending
        step(1, 0, 0, 8'h00, 0);
        for (int i = 0; i < 16; i++) step(1, 1, 0, 8'(i), 0);
        step(1, 1, 0, 8'hEE, 0);
        step(1, 1, 1, 8'hEF, 0);
        mid_reset();
        check_status();

        // clear_err loses to a simultaneous new error
        step(0, 0, 1, 8'h00, 0);
        step(0, 0, 1, 8'h00, 1);
        step(0, 0, 0, 8'h00, 1);

        // Randomized traffic with varying push/pop bias
        rm = 0;
        for (int blk = 0; blk < 8; blk++) begin
            pw = $urandom_range(20, 80);
            pp = $urandom_range(20, 80);
            for (int i = 0; i < 100; i++) begin
                if ($urandom_range(0, 15) == 0) rm = ~rm;
                step(rm,
                     $urandom_range(0, 99) < pw,
                     $urandom_range(0, 99) < pp,
                     8'($urandom),
                     $urandom_range(0, 7) == 0);
            end
        end

        step(rm, 0, 0, 8'h00, 0);
        chk("sb_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
